// File: rtl/viking_bus_pkg.sv
// Shared types and constants for the ST RAM bus-slot scheduler.
package viking_bus_pkg;

  localparam int ADDR_W = 23;

  localparam logic [1:0] SLOT_VIDEO0 = 2'd0;
  localparam logic [1:0] SLOT_VIDEO2 = 2'd2;

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_SHIFTER,
    OWN_VIKING,
    OWN_DMA,
    OWN_REFRESH
  } owner_e;

endpackage

// File: rtl/viking_refresh_timer.sv
// DRAM refresh request timer: period down-counter, single pending flag and
// starvation counter that escalates a long-waiting refresh to urgent.
module viking_refresh_timer #(
  parameter int REFRESH_PERIOD = 30,
  parameter int STARVE_MAX     = 8
) (
  input  logic clk_32,
  input  logic reset,
  input  logic wrap,
  input  logic granted,
  output logic pending,
  output logic urgent
);

  localparam int CNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_PERIOD - 1);
  // A limit above 15 can never be reached by the 4-bit counter.
  localparam logic [4:0] STARVE_LIM = (STARVE_MAX > 16) ? 5'd16 : 5'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [3:0]       starve_q, starve_d;
  logic             expire;

  always_comb begin
    expire    = wrap && (cnt_q == '0);
    cnt_d     = cnt_q;
    pending_d = pending_q;
    starve_d  = starve_q;
    if (wrap) begin
      cnt_d = expire ? RELOAD : (cnt_q - CNT_W'(1));
      if (pending_q && (starve_q != 4'hf)) begin
        starve_d = starve_q + 4'd1;
      end
    end
    if (granted) begin
      pending_d = 1'b0;
      starve_d  = 4'd0;
    end
    // A fresh expiry survives a same-edge grant; an expiry while pending is lost.
    if (expire) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_32) begin
    if (reset) begin
      cnt_q     <= RELOAD;
      pending_q <= 1'b0;
      starve_q  <= 4'd0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      starve_q  <= starve_d;
    end
  end

  assign pending = pending_q;
  assign urgent  = ({1'b0, starve_q} >= STARVE_LIM);

endmodule

// File: rtl/viking_bus_sched.sv
// ST RAM bus-slot scheduler: 4-phase slot counter, video-slot arbitration
// between shifter, Viking, DMA and refresh, registered RAM command and acks.
module viking_bus_sched
  import viking_bus_pkg::*;
#(
  parameter int REFRESH_PERIOD = 30,
  parameter int STARVE_MAX     = 8
) (
  input  logic              clk_32,
  input  logic              reset,
  input  logic              bclk_en,
  input  logic              viking_en,
  input  logic              shifter_req,
  input  logic [ADDR_W-1:0] shifter_addr,
  input  logic              viking_req,
  input  logic [ADDR_W-1:0] viking_addr,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  output logic [1:0]        bus_cycle,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              ram_refresh,
  output logic              shifter_ack,
  output logic              viking_ack,
  output logic              dma_ack
);

  logic [1:0]        bus_cycle_q, bus_cycle_d, next_slot;
  owner_e            owner_q, owner_d, pick;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_oe_q, ram_oe_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_refresh_q, ram_refresh_d;
  logic              shifter_ack_q, shifter_ack_d;
  logic              viking_ack_q, viking_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic              wrap, ref_pending, ref_urgent, ref_granted;

  assign next_slot   = bus_cycle_q + 2'd1;
  assign wrap        = bclk_en && (bus_cycle_q == 2'd3);
  assign ref_granted = bclk_en && (pick == OWN_REFRESH);

  viking_refresh_timer #(
    .REFRESH_PERIOD (REFRESH_PERIOD),
    .STARVE_MAX     (STARVE_MAX)
  ) u_refresh (
    .clk_32  (clk_32),
    .reset   (reset),
    .wrap    (wrap),
    .granted (ref_granted),
    .pending (ref_pending),
    .urgent  (ref_urgent)
  );

  // Request/ack handshake: a *_req level is sampled only on the bclk_en that
  // enters a video slot; the winner owns the whole slot regardless of later
  // req changes, and its *_ack is a single-clock strobe after the slot ends.
  always_comb begin
    pick = OWN_NONE;
    if (next_slot == SLOT_VIDEO0) begin
      if (shifter_req)      pick = OWN_SHIFTER;
      else if (ref_urgent)  pick = OWN_REFRESH;
      else if (dma_req)     pick = OWN_DMA;
      else if (ref_pending) pick = OWN_REFRESH;
    end else if (next_slot == SLOT_VIDEO2) begin
      if (ref_urgent)                   pick = OWN_REFRESH;
      else if (viking_en && viking_req) pick = OWN_VIKING;
      else if (ref_pending)             pick = OWN_REFRESH;
      else if (dma_req)                 pick = OWN_DMA;
    end
  end

  always_comb begin
    bus_cycle_d   = bus_cycle_q;
    owner_d       = owner_q;
    ram_addr_d    = ram_addr_q;
    ram_oe_d      = ram_oe_q;
    ram_we_d      = ram_we_q;
    ram_refresh_d = ram_refresh_q;
    shifter_ack_d = 1'b0;
    viking_ack_d  = 1'b0;
    dma_ack_d     = 1'b0;
    if (bclk_en) begin
      bus_cycle_d   = next_slot;
      owner_d       = pick;
      shifter_ack_d = (owner_q == OWN_SHIFTER);
      viking_ack_d  = (owner_q == OWN_VIKING);
      dma_ack_d     = (owner_q == OWN_DMA);
      ram_addr_d    = '0;
      ram_oe_d      = 1'b0;
      ram_we_d      = 1'b0;
      ram_refresh_d = 1'b0;
      case (pick)
        OWN_SHIFTER: begin
          ram_addr_d = shifter_addr;
          ram_oe_d   = 1'b1;
        end
        OWN_VIKING: begin
          ram_addr_d = viking_addr;
          ram_oe_d   = 1'b1;
        end
        OWN_DMA: begin
          ram_addr_d = dma_addr;
          ram_oe_d   = !dma_we;
          ram_we_d   = dma_we;
        end
        OWN_REFRESH: ram_refresh_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_32) begin
    if (reset) begin
      bus_cycle_q   <= 2'd0;
      owner_q       <= OWN_NONE;
      ram_addr_q    <= '0;
      ram_oe_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_refresh_q <= 1'b0;
      shifter_ack_q <= 1'b0;
      viking_ack_q  <= 1'b0;
      dma_ack_q     <= 1'b0;
    end else begin
      bus_cycle_q   <= bus_cycle_d;
      owner_q       <= owner_d;
      ram_addr_q    <= ram_addr_d;
      ram_oe_q      <= ram_oe_d;
      ram_we_q      <= ram_we_d;
      ram_refresh_q <= ram_refresh_d;
      shifter_ack_q <= shifter_ack_d;
      viking_ack_q  <= viking_ack_d;
      dma_ack_q     <= dma_ack_d;
    end
  end

  assign bus_cycle   = bus_cycle_q;
  assign ram_addr    = ram_addr_q;
  assign ram_oe      = ram_oe_q;
  assign ram_we      = ram_we_q;
  assign ram_refresh = ram_refresh_q;
  assign shifter_ack = shifter_ack_q;
  assign viking_ack  = viking_ack_q;
  assign dma_ack     = dma_ack_q;

endmodule
